// File: rtl/uart_tx_arb_pkg.sv
// Shared definitions for the UART transmit arbiter: FSM state encoding,
// baud-rate derived gap defaults and small elaboration-time helpers.
package uart_tx_arb_pkg;

  // FSM state type and encoding, kept as plain constants so older tools and
  // netlists that expect a bare 2-bit state vector still line up.
  typedef logic [1:0] arb_state_t;

  localparam arb_state_t ST_IDLE    = 2'd0;
  localparam arb_state_t ST_LAUNCH  = 2'd1;
  localparam arb_state_t ST_RELEASE = 2'd2;
  localparam arb_state_t ST_GAP     = 2'd3;

  // Idle cycles after busy falls that cover one full stop bit on a 50 MHz clock.
  localparam int GAP_CYCLES_115200 = 434;
  localparam int GAP_CYCLES_9600   = 5208;

  // Default number of cycles the arbiter waits for the transmitter to go busy.
  localparam int ACK_TIMEOUT_DEFAULT = 15;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  // Width of a requester index; never narrower than one bit.
  function automatic int index_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/uart_tx_arb_rr_pick.sv
// Combinational round-robin selector: starting at the pointer, picks the first
// active request and reports it both one-hot and as an index.
module rr_pick
  import uart_tx_arb_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int IDX_W = index_width(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N_REQ-1:0] grant,
  output logic [IDX_W-1:0] grant_idx,
  output logic             grant_any
);

  // Position k steps after the pointer, wrapped into the requester range.
  function automatic int wrap_pos(input logic [IDX_W-1:0] p, input int k);
    return (int'(p) + k) % N_REQ;
  endfunction

  // Scan all requesters in priority order from the pointer; first hit wins.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    grant_any = 1'b0;
    for (int k = 0; k < N_REQ; k++) begin
      if (!grant_any && req[wrap_pos(ptr, k)]) begin
        grant[wrap_pos(ptr, k)] = 1'b1;
        grant_idx               = IDX_W'(wrap_pos(ptr, k));
        grant_any               = 1'b1;
      end
    end
  end

endmodule

// File: rtl/uart_tx_arb.sv
// Round-robin arbiter feeding bytes from several requesters into one serial
// transmitter. Each byte is launched with a tx_en rising edge, the arbiter
// waits for the transmitter to finish, then holds off for a stop-bit gap
// before serving the next requester.
module uart_tx_arb
  import uart_tx_arb_pkg::*;
#(
  parameter int N_REQ       = 4,
  parameter int GAP_CYCLES  = GAP_CYCLES_115200,
  parameter int ACK_TIMEOUT = ACK_TIMEOUT_DEFAULT
) (
  input  logic                           sys_clk,
  input  logic                           rst,
  input  logic [N_REQ-1:0]               req_valid,
  input  logic [8*N_REQ-1:0]             req_data,
  output logic [N_REQ-1:0]               req_ready,
  output logic [7:0]                     tx_data,
  output logic                           tx_en,
  input  logic                           tx_busy,
  output logic [index_width(N_REQ)-1:0]  grant_id,
  output logic                           active,
  output logic                           err_timeout
);

  localparam int IDX_W = index_width(N_REQ);

  // One counter serves both the launch timeout and the gap; sized so that
  // neither terminal count can wrap it.
  localparam int CNT_W = $clog2(max_int(GAP_CYCLES, ACK_TIMEOUT) + 1);

  localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(GAP_CYCLES - 1);
  localparam logic [CNT_W-1:0] ACK_LAST = CNT_W'(ACK_TIMEOUT - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_REQ - 1);

  arb_state_t       state;
  logic [CNT_W-1:0] cnt;
  logic [IDX_W-1:0] rr_ptr;

  logic [N_REQ-1:0] pick_onehot;
  logic [IDX_W-1:0] pick_idx;
  logic             pick_any;
  logic [7:0]       pick_byte;

  rr_pick #(
    .N_REQ (N_REQ),
    .IDX_W (IDX_W)
  ) u_rr_pick (
    .req       (req_valid),
    .ptr       (rr_ptr),
    .grant     (pick_onehot),
    .grant_idx (pick_idx),
    .grant_any (pick_any)
  );

  // Select the winner's byte out of the flattened request data bus.
  always_comb begin
    pick_byte = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (pick_idx == IDX_W'(i)) begin
        pick_byte = req_data[8*i +: 8];
      end
    end
  end

  assign active = (state != ST_IDLE);

  // Arbitration FSM: grant in IDLE, hold tx_en until the transmitter goes
  // busy (or give up), wait for busy to clear, then enforce the idle gap.
  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      state       <= ST_IDLE;
      cnt         <= '0;
      rr_ptr      <= '0;
      tx_en       <= 1'b0;
      tx_data     <= '0;
      req_ready   <= '0;
      grant_id    <= '0;
      err_timeout <= 1'b0;
    end else begin
      req_ready   <= '0;
      err_timeout <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (pick_any) begin
            tx_data   <= pick_byte;
            grant_id  <= pick_idx;
            req_ready <= pick_onehot;
            tx_en     <= 1'b1;
            cnt       <= '0;
            rr_ptr    <= (pick_idx == IDX_LAST) ? '0 : pick_idx + 1'b1;
            state     <= ST_LAUNCH;
          end
        end
        ST_LAUNCH: begin
          if (tx_busy) begin
            tx_en <= 1'b0;
            state <= ST_RELEASE;
          end else if (cnt == ACK_LAST) begin
            tx_en       <= 1'b0;
            err_timeout <= 1'b1;
            cnt         <= '0;
            state       <= ST_GAP;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ST_RELEASE: begin
          if (!tx_busy) begin
            cnt   <= '0;
            state <= ST_GAP;
          end
        end
        ST_GAP: begin
          if (cnt == GAP_LAST) begin
            cnt   <= '0;
            state <= ST_IDLE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          tx_en <= 1'b0;
          cnt   <= '0;
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
